// File: rtl/recovery_ctrl_if.sv
// Mispredict recovery bus: predictor/ROB/LSB status in, flush and fetch redirect out.
// master = pipeline side, slave = recovery controller.
interface recovery_ctrl_if #(parameter int TAG_W = 4);
  logic             rdy;
  logic [TAG_W:0]   mp_tag;
  logic [31:0]      mp_pc;
  logic [TAG_W-1:0] rob_head;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             mem_busy;
  logic             flush;
  logic             pc_set;
  logic [31:0]      pc_out;
  logic             stall_fetch;
  logic [15:0]      mp_count;

  modport master (
    output rdy, mp_tag, mp_pc, rob_head, commit_valid, commit_tag, mem_busy,
    input  flush, pc_set, pc_out, stall_fetch, mp_count
  );

  modport slave (
    input  rdy, mp_tag, mp_pc, rob_head, commit_valid, commit_tag, mem_busy,
    output flush, pc_set, pc_out, stall_fetch, mp_count
  );
endinterface

// File: rtl/recovery_ctrl.sv
// Branch mispredict recovery: waits for the mispredicted branch to commit, flushes,
// drains outstanding memory traffic, then redirects fetch to the corrected PC.
module recovery_ctrl #(
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  recovery_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COMMIT,
    FLUSH,
    DRAIN,
    REFETCH
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] pend_tag;
  logic [31:0]      pend_pc;

  logic             report_valid;
  logic [TAG_W-1:0] report_tag;
  logic [TAG_W-1:0] report_age;
  logic [TAG_W-1:0] pend_age;
  logic             commit_hit_pend;
  logic             commit_hit_report;

  // Age is distance from the ROB head, wrapping naturally at TAG_W bits.
  assign report_valid      = bus.mp_tag[TAG_W];
  assign report_tag        = bus.mp_tag[TAG_W-1:0];
  assign report_age        = report_tag - bus.rob_head;
  assign pend_age          = pend_tag - bus.rob_head;
  assign commit_hit_pend   = bus.commit_valid && (bus.commit_tag == pend_tag);
  assign commit_hit_report = bus.commit_valid && (bus.commit_tag == report_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pend_tag        <= '0;
      pend_pc         <= '0;
      bus.flush       <= 1'b0;
      bus.pc_set      <= 1'b0;
      bus.pc_out      <= '0;
      bus.stall_fetch <= 1'b0;
      bus.mp_count    <= '0;
    end else if (!bus.rdy) begin
      // Frozen: pulses drop so they never stretch, everything else holds.
      bus.flush  <= 1'b0;
      bus.pc_set <= 1'b0;
    end else begin
      bus.flush  <= 1'b0;
      bus.pc_set <= 1'b0;
      case (state)
        IDLE: begin
          if (report_valid) begin
            pend_tag        <= report_tag;
            pend_pc         <= bus.mp_pc;
            bus.stall_fetch <= 1'b1;
            if (commit_hit_report) begin
              state     <= FLUSH;
              bus.flush <= 1'b1;
            end else begin
              state <= WAIT_COMMIT;
            end
          end
        end
        WAIT_COMMIT: begin
          // A commit of the pending branch wins over any same-cycle replacement.
          if (commit_hit_pend) begin
            state     <= FLUSH;
            bus.flush <= 1'b1;
          end else if (report_valid && (report_age < pend_age)) begin
            pend_tag <= report_tag;
            pend_pc  <= bus.mp_pc;
          end
        end
        FLUSH: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.mem_busy) begin
            state      <= REFETCH;
            bus.pc_set <= 1'b1;
            bus.pc_out <= pend_pc;
            if (bus.mp_count != 16'hFFFF) begin
              bus.mp_count <= bus.mp_count + 16'd1;
            end
          end
        end
        REFETCH: begin
          state           <= IDLE;
          bus.stall_fetch <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.stall_fetch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_ctrl.sv
// Recovery controller bench: directed scenarios with literal pins, then random traffic,
// all checked every cycle against a step-counting behavioural model.
module tb_recovery_ctrl;
  localparam int TAG_W = 4;
  localparam int ROB   = 1 << TAG_W;

  logic clk;
  logic rst;

  recovery_ctrl_if #(.TAG_W(TAG_W)) bus ();

  recovery_ctrl #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: waiting for a branch to commit, or counting active steps since the flush decision.
  logic             m_wait;
  int               m_k;
  logic             m_done;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_pc;
  logic             exp_flush;
  logic             exp_pc_set;
  logic             exp_stall;
  logic [31:0]      exp_pc_out;
  logic [15:0]      exp_count;

  logic             pin_on;
  logic             pin_flush;
  logic             pin_pc_set;
  logic             pin_stall;
  logic [31:0]      pin_pc_out;
  logic [15:0]      pin_count;
  logic             seed_now;

  function automatic int age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
    return (int'(t) - int'(h) + ROB) % ROB;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 1'b0; m_k = -1; m_done = 1'b0; m_tag = '0; m_pc = '0;
      exp_flush = 1'b0; exp_pc_set = 1'b0; exp_stall = 1'b0;
      exp_pc_out = '0; exp_count = '0;
    end else if (seed_now) begin
      exp_count = 16'hFFFE;
    end else if (!bus.rdy) begin
      exp_flush  = 1'b0;
      exp_pc_set = 1'b0;
    end else begin
      exp_flush  = 1'b0;
      exp_pc_set = 1'b0;
      if (m_k >= 0) begin
        m_k++;
        if (m_done) begin
          m_k       = -1;
          exp_stall = 1'b0;
        end else if (m_k >= 2 && !bus.mem_busy) begin
          exp_pc_set = 1'b1;
          exp_pc_out = m_pc;
          if (exp_count != 16'hFFFF) exp_count++;
          m_done = 1'b1;
        end
      end else if (m_wait) begin
        if (bus.commit_valid && bus.commit_tag == m_tag) begin
          m_wait = 1'b0; m_k = 0; m_done = 1'b0; exp_flush = 1'b1;
        end else if (bus.mp_tag[TAG_W] &&
                     age(bus.mp_tag[TAG_W-1:0], bus.rob_head) < age(m_tag, bus.rob_head)) begin
          m_tag = bus.mp_tag[TAG_W-1:0];
          m_pc  = bus.mp_pc;
        end
      end else if (bus.mp_tag[TAG_W]) begin
        m_tag     = bus.mp_tag[TAG_W-1:0];
        m_pc      = bus.mp_pc;
        exp_stall = 1'b1;
        if (bus.commit_valid && bus.commit_tag == bus.mp_tag[TAG_W-1:0]) begin
          m_k = 0; m_done = 1'b0; exp_flush = 1'b1;
        end else begin
          m_wait = 1'b1;
        end
      end
    end
    #1;
    vectors++;
    cmp("flush",       32'(bus.flush),       32'(exp_flush));
    cmp("pc_set",      32'(bus.pc_set),      32'(exp_pc_set));
    cmp("stall_fetch", 32'(bus.stall_fetch), 32'(exp_stall));
    cmp("pc_out",      bus.pc_out,           exp_pc_out);
    cmp("mp_count",    32'(bus.mp_count),    32'(exp_count));
    if (pin_on) begin
      cmp("pin_flush",    32'(bus.flush),       32'(pin_flush));
      cmp("pin_pc_set",   32'(bus.pc_set),      32'(pin_pc_set));
      cmp("pin_stall",    32'(bus.stall_fetch), 32'(pin_stall));
      cmp("pin_pc_out",   bus.pc_out,           pin_pc_out);
      cmp("pin_mp_count", 32'(bus.mp_count),    32'(pin_count));
    end
  end

  task automatic pin_next(input logic f, input logic ps, input logic st,
                          input logic [31:0] pc, input logic [15:0] cnt);
    pin_on     = 1'b1;
    pin_flush  = f;
    pin_pc_set = ps;
    pin_stall  = st;
    pin_pc_out = pc;
    pin_count  = cnt;
  endtask

  task automatic apply_stimulus(input logic r, input logic rd, input logic mv,
                                input logic [TAG_W-1:0] mt, input logic [31:0] pc,
                                input logic [TAG_W-1:0] head, input logic cv,
                                input logic [TAG_W-1:0] ct, input logic busy);
    rst              = r;
    bus.rdy          = rd;
    bus.mp_tag       = {mv, mt};
    bus.mp_pc        = pc;
    bus.rob_head     = head;
    bus.commit_valid = cv;
    bus.commit_tag   = ct;
    bus.mem_busy     = busy;
    @(negedge clk);
    pin_on = 1'b0;
  endtask

  task automatic idle_step(input logic rd, input logic busy);
    apply_stimulus(1'b0, rd, 1'b0, '0, 32'h0, '0, 1'b0, '0, busy);
  endtask

  logic             r_rst, r_rdy, r_mv, r_cv, r_busy;
  logic [TAG_W-1:0] r_mt, r_head, r_ct;

  initial begin
    pin_on   = 1'b0;
    seed_now = 1'b0;

    // Reset wins even with rdy low.
    pin_next(0, 0, 0, 32'h0, 16'd0);
    apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 0);

    // Basic recovery, head=2, branch tag 5 commits two cycles after the report.
    pin_next(0, 0, 1, 32'h0, 16'd0);
    apply_stimulus(0, 1, 1, 5, 32'h1000, 2, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 2, 0, 0, 0);
    pin_next(1, 0, 1, 32'h0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 2, 1, 5, 0);
    pin_next(0, 0, 1, 32'h0, 16'd0);
    idle_step(1, 0);
    pin_next(0, 1, 1, 32'h1000, 16'd1);
    idle_step(1, 0);
    pin_next(0, 0, 0, 32'h1000, 16'd1);
    idle_step(1, 0);

    // Report and commit of the same tag in one cycle: flush straight away.
    pin_next(1, 0, 1, 32'h1000, 16'd1);
    apply_stimulus(0, 1, 1, 3, 32'h2000, 0, 1, 3, 0);
    idle_step(1, 0);
    pin_next(0, 1, 1, 32'h2000, 16'd2);
    idle_step(1, 0);
    idle_step(1, 0);

    // Older replacement around head=14; equal and younger reports ignored.
    apply_stimulus(0, 1, 1, 2,  32'h200, 14, 0, 0, 0);
    apply_stimulus(0, 1, 1, 15, 32'h300, 14, 0, 0, 0);
    apply_stimulus(0, 1, 1, 15, 32'h999, 14, 0, 0, 0);
    apply_stimulus(0, 1, 1, 4,  32'h400, 14, 0, 0, 0);
    pin_next(0, 0, 1, 32'h2000, 16'd2);
    apply_stimulus(0, 1, 0, 0,  32'h0,   14, 1, 2, 0);
    pin_next(1, 0, 1, 32'h2000, 16'd2);
    apply_stimulus(0, 1, 1, 4,  32'h400, 14, 1, 15, 0);
    apply_stimulus(0, 1, 1, 4,  32'h444, 14, 0, 0, 0);
    pin_next(0, 1, 1, 32'h300, 16'd3);
    apply_stimulus(0, 1, 1, 4,  32'h444, 14, 0, 0, 0);
    pin_next(0, 0, 0, 32'h300, 16'd3);
    apply_stimulus(0, 1, 1, 4,  32'h444, 14, 0, 0, 0);
    idle_step(1, 0);

    // Older report in the same cycle as the pending commit keeps the old pc.
    apply_stimulus(0, 1, 1, 6, 32'hA00, 0, 0, 0, 0);
    pin_next(1, 0, 1, 32'h300, 16'd3);
    apply_stimulus(0, 1, 1, 3, 32'hB00, 0, 1, 6, 0);
    idle_step(1, 0);
    pin_next(0, 1, 1, 32'hA00, 16'd4);
    idle_step(1, 0);
    idle_step(1, 0);

    // Memory busy for five cycles after the flush.
    pin_next(1, 0, 1, 32'hA00, 16'd4);
    apply_stimulus(0, 1, 1, 7, 32'h700, 7, 1, 7, 1);
    for (int i = 0; i < 5; i++) begin
      pin_next(0, 0, 1, 32'hA00, 16'd4);
      idle_step(1, 1);
    end
    pin_next(0, 1, 1, 32'h700, 16'd5);
    idle_step(1, 0);
    idle_step(1, 0);

    // rdy low for three cycles in DRAIN and again in REFETCH.
    apply_stimulus(0, 1, 1, 1, 32'h111, 0, 1, 1, 0);
    idle_step(1, 0);
    for (int i = 0; i < 3; i++) begin
      pin_next(0, 0, 1, 32'h700, 16'd5);
      idle_step(0, 0);
    end
    pin_next(0, 1, 1, 32'h111, 16'd6);
    idle_step(1, 0);
    for (int i = 0; i < 3; i++) begin
      pin_next(0, 0, 1, 32'h111, 16'd6);
      idle_step(0, 0);
    end
    pin_next(0, 0, 0, 32'h111, 16'd6);
    idle_step(1, 0);

    // Reset during WAIT_COMMIT aborts; the stale commit does nothing afterwards.
    apply_stimulus(0, 1, 1, 9, 32'h900, 0, 0, 0, 0);
    pin_next(0, 0, 0, 32'h0, 16'd0);
    apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    pin_next(0, 0, 0, 32'h0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 0, 1, 9, 0);

    // Counter saturation: preload 16'hFFFE, then two recoveries.
    force bus.mp_count = 16'hFFFE;
    seed_now = 1'b1;
    idle_step(1, 0);
    release bus.mp_count;
    seed_now = 1'b0;
    apply_stimulus(0, 1, 1, 2, 32'h222, 0, 1, 2, 0);
    idle_step(1, 0);
    pin_next(0, 1, 1, 32'h222, 16'hFFFF);
    idle_step(1, 0);
    idle_step(1, 0);
    apply_stimulus(0, 1, 1, 3, 32'h333, 0, 1, 3, 0);
    idle_step(1, 0);
    pin_next(0, 1, 1, 32'h333, 16'hFFFF);
    idle_step(1, 0);
    idle_step(1, 0);

    // Random traffic, commits biased toward the branch the model is waiting on.
    for (int i = 0; i < 4000; i++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_rdy  = ($urandom_range(0, 9) != 0);
      r_mv   = ($urandom_range(0, 9) < 3);
      r_mt   = TAG_W'($urandom_range(0, ROB - 1));
      r_head = TAG_W'($urandom_range(0, ROB - 1));
      r_cv   = ($urandom_range(0, 9) < 4);
      r_ct   = ($urandom_range(0, 1) == 1) ? m_tag : TAG_W'($urandom_range(0, ROB - 1));
      r_busy = ($urandom_range(0, 9) < 4);
      apply_stimulus(r_rst, r_rdy, r_mv, r_mt, $urandom, r_head, r_cv, r_ct, r_busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
